// File: rtl/ahb_lite_copy_master_if.sv
// ahb_lite_copy_master_if: AHB-Lite bus bundle between the copy master and the slave side
interface ahb_lite_copy_master_if;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        input  HRDATA, HREADY, HRESP
    );
    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_lite_copy_master.sv
// ahb_lite_copy_master: AHB-Lite initiator copying 32-bit words with single read/write transfers
module ahb_lite_copy_master #(
    parameter int CNT_W = 16
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic                   start,
    input  logic [31:0]            src_addr,
    input  logic [31:0]            dst_addr,
    input  logic [CNT_W-1:0]       word_count,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [CNT_W-1:0]       words_left,
    ahb_lite_copy_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_A, WR_D, DONE} state_t;
    state_t           state, state_n;
    logic [31:0]      src, src_n, dst, dst_n, data_buf, buf_n;
    logic [CNT_W-1:0] left_n;
    logic             err_n;
    assign bus.HSIZE     = 3'b010;
    assign bus.HBURST    = 3'b000;
    assign bus.HPROT     = 4'b0011;
    assign bus.HMASTLOCK = 1'b0;
    // next state and datapath updates; an ERROR response exits on its first cycle
    always_comb begin
        state_n = state;
        src_n   = src;
        dst_n   = dst;
        buf_n   = data_buf;
        left_n  = words_left;
        err_n   = error;
        case (state)
            IDLE: if (start) begin
                src_n   = {src_addr[31:2], 2'b00};
                dst_n   = {dst_addr[31:2], 2'b00};
                left_n  = word_count;
                err_n   = 1'b0;
                state_n = (word_count == '0) ? DONE : RD_A;
            end
            RD_A: state_n = bus.HREADY ? RD_D : RD_A;
            RD_D: if (bus.HRESP) begin
                err_n   = 1'b1;
                state_n = DONE;
            end else if (bus.HREADY) begin
                buf_n   = bus.HRDATA;
                state_n = WR_A;
            end
            WR_A: state_n = bus.HREADY ? WR_D : WR_A;
            WR_D: if (bus.HRESP) begin
                err_n   = 1'b1;
                state_n = DONE;
            end else if (bus.HREADY) begin
                src_n   = src + 32'd4;
                dst_n   = dst + 32'd4;
                left_n  = words_left - CNT_W'(1);
                state_n = (words_left == CNT_W'(1)) ? DONE : RD_A;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    // state, datapath and registered bus/status outputs derived from the next state
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state      <= IDLE;
            src        <= '0;
            dst        <= '0;
            data_buf   <= '0;
            words_left <= '0;
            error      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bus.HTRANS <= 2'b00;
            bus.HADDR  <= '0;
            bus.HWRITE <= 1'b0;
            bus.HWDATA <= '0;
        end else begin
            state      <= state_n;
            src        <= src_n;
            dst        <= dst_n;
            data_buf   <= buf_n;
            words_left <= left_n;
            error      <= err_n;
            busy       <= state_n inside {RD_A, RD_D, WR_A, WR_D};
            done       <= state_n == DONE;
            bus.HTRANS <= (state_n == RD_A || state_n == WR_A) ? 2'b10 : 2'b00;
            bus.HADDR  <= state_n == RD_A ? src_n : state_n == WR_A ? dst_n : bus.HADDR;
            bus.HWRITE <= state_n == WR_A ? 1'b1 : state_n == RD_A ? 1'b0 : bus.HWRITE;
            bus.HWDATA <= state_n == WR_D ? buf_n : bus.HWDATA;
        end
    end
endmodule

// File: tb/tb_ahb_lite_copy_master.sv
// tb_ahb_lite_copy_master: vector table of copy commands against a wait/error-capable memory slave
module tb_ahb_lite_copy_master;
    logic        HCLK, HRESET, start;
    logic [31:0] src_addr, dst_addr;
    logic [15:0] word_count, words_left;
    logic        busy, done, error;
    ahb_lite_copy_master_if bus();
    ahb_lite_copy_master #(.CNT_W(16)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .word_count(word_count), .busy(busy), .done(done), .error(error),
        .words_left(words_left), .bus(bus.master)
    );
    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [31:0] src, dst;
        int cnt, waits, err_rd, mid, exp_cyc, exp_err, exp_left, exp_wr, exp_ns;
    } vec_t;
    vec_t vecs[9];
    int checks = 0, errors = 0;
    logic [63:0] exp_wr_q[$];
    logic [31:0] exp_rd_q[$];

    // slave model state: only the slave process writes these
    logic [31:0] mem[0:1023];
    bit          wrt[0:1023];
    logic [31:0] rd_log[0:255], wr_a_log[0:255], wr_d_log[0:255];
    int          rd_n = 0, wr_n = 0, ns_n = 0, stab_err = 0;
    bit          dp_act = 0, dp_wr = 0, dp_err = 0, wd_set = 0;
    logic [31:0] dp_addr = '0, wd = '0;
    int          wl = 0, es = 0;
    // slave configuration: only the stimulus process writes these
    int          waits_cfg = 0, err_at = -1, rd_p = 0, wr_p = 0;

    function automatic logic [31:0] init_val(input logic [9:0] i);
        return (i < 10'd4) ? 32'h11111111 * (32'(i) + 32'd1) : 32'hC0DE_0000 | 32'(i);
    endfunction

    function automatic logic [31:0] rd_word(input logic [9:0] i);
        return wrt[i] ? mem[i] : init_val(i);
    endfunction

    // memory slave: registered HREADY/HRESP/HRDATA, optional wait states and two-cycle ERROR
    always @(posedge HCLK) begin
        if (HRESET) begin
            dp_act = 0;
            es = 0;
            bus.HREADY <= 1'b1;
            bus.HRESP  <= 1'b0;
            bus.HRDATA <= '0;
        end else begin
            if (bus.HREADY) begin
                if (dp_act && dp_wr && !bus.HRESP) begin
                    if (wd_set && bus.HWDATA != wd) stab_err++;
                    mem[dp_addr[11:2]] = bus.HWDATA;
                    wrt[dp_addr[11:2]] = 1;
                    wr_a_log[wr_n] = dp_addr;
                    wr_d_log[wr_n] = bus.HWDATA;
                    wr_n++;
                end
                dp_act = bus.HTRANS == 2'b10;
                if (dp_act) begin
                    ns_n++;
                    dp_wr = bus.HWRITE;
                    dp_addr = bus.HADDR;
                    wl = waits_cfg;
                    es = 0;
                    wd_set = 0;
                    dp_err = !bus.HWRITE && rd_n == err_at;
                    if (!bus.HWRITE) begin
                        rd_log[rd_n] = bus.HADDR;
                        rd_n++;
                    end
                end
            end else if (dp_act) begin
                if (bus.HADDR != dp_addr || bus.HWRITE != dp_wr || bus.HTRANS != 2'b00) stab_err++;
                if (dp_wr && wd_set && bus.HWDATA != wd) stab_err++;
                if (dp_wr) begin
                    wd = bus.HWDATA;
                    wd_set = 1;
                end
            end
            if (!dp_act) begin
                bus.HREADY <= 1'b1;
                bus.HRESP  <= 1'b0;
            end else if (dp_err) begin
                bus.HREADY <= es == 1;
                bus.HRESP  <= 1'b1;
                es = 1;
            end else if (wl > 0) begin
                bus.HREADY <= 1'b0;
                bus.HRESP  <= 1'b0;
                wl--;
            end else begin
                bus.HREADY <= 1'b1;
                bus.HRESP  <= 1'b0;
                bus.HRDATA <= dp_wr ? 32'h0 : rd_word(dp_addr[11:2]);
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // pop scoreboard entries for every transfer the slave has logged so far
    task automatic drain();
        while (rd_p < rd_n) begin
            chk("rd_expected", 64'(exp_rd_q.size() != 0), 64'd1);
            if (exp_rd_q.size() != 0) chk("rd_addr", 64'(rd_log[rd_p]), 64'(exp_rd_q.pop_front()));
            rd_p++;
        end
        while (wr_p < wr_n) begin
            chk("wr_expected", 64'(exp_wr_q.size() != 0), 64'd1);
            if (exp_wr_q.size() != 0) chk("wr_addr_data", {wr_a_log[wr_p], wr_d_log[wr_p]}, exp_wr_q.pop_front());
            wr_p++;
        end
    endtask

    task automatic run(input vec_t v, input int idx);
        int cyc, ns0, st0, wr0;
        bit busy_seen;
        logic [31:0] a, d;
        string nm;
        nm = $sformatf("v%0d", idx);
        ns0 = ns_n;
        st0 = stab_err;
        wr0 = wr_n;
        busy_seen = 0;
        waits_cfg = v.waits;
        err_at = v.err_rd < 0 ? -1 : rd_n + v.err_rd;
        for (int i = 0; i < v.exp_wr; i++) begin
            a = v.src + 32'(4 * i);
            d = v.dst + 32'(4 * i);
            exp_wr_q.push_back({d, init_val(a[11:2])});
        end
        for (int i = 0; i < v.exp_wr + (v.err_rd >= 0 ? 1 : 0); i++) exp_rd_q.push_back(v.src + 32'(4 * i));
        @(negedge HCLK);
        src_addr = v.src;
        dst_addr = v.dst;
        word_count = 16'(v.cnt);
        start = 1'b1;
        @(negedge HCLK);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 400) begin
            busy_seen |= busy;
            drain();
            if (v.mid != 0 && cyc == 3) begin
                start = 1'b1;
                src_addr = 32'h0;
                dst_addr = 32'hC00;
                word_count = 16'd5;
            end else start = 1'b0;
            @(negedge HCLK);
            cyc++;
        end
        start = 1'b0;
        drain();
        chk({nm, "_done_cycle"}, 64'(cyc), 64'(v.exp_cyc));
        chk({nm, "_error"}, 64'(error), 64'(v.exp_err));
        chk({nm, "_words_left"}, 64'(words_left), 64'(v.exp_left));
        chk({nm, "_busy_at_done"}, 64'(busy), 64'd0);
        chk({nm, "_busy_seen"}, 64'(busy_seen), 64'(v.cnt != 0));
        @(negedge HCLK);
        drain();
        chk({nm, "_done_pulse"}, 64'(done), 64'd0);
        chk({nm, "_write_count"}, 64'(wr_n - wr0), 64'(v.exp_wr));
        chk({nm, "_nonseq_count"}, 64'(ns_n - ns0), 64'(v.exp_ns));
        chk({nm, "_stable"}, 64'(stab_err - st0), 64'd0);
        chk({nm, "_wr_left"}, 64'(exp_wr_q.size()), 64'd0);
        chk({nm, "_rd_left"}, 64'(exp_rd_q.size()), 64'd0);
    endtask

    initial begin
        bit found, done_seen, trans_seen;
        vecs[0] = '{32'h0000_0000, 32'h0000_0100, 4, 0, -1, 0, 17, 0, 0, 4, 8};
        vecs[1] = '{32'h0000_0040, 32'h0000_0140, 0, 0, -1, 0, 1, 0, 0, 0, 0};
        vecs[2] = '{32'h0000_0008, 32'h0000_0300, 2, 2, -1, 0, 17, 0, 0, 2, 4};
        vecs[3] = '{32'h0000_0200, 32'h0000_0400, 3, 0, 1, 0, 7, 1, 2, 1, 3};
        vecs[4] = '{32'h0000_0020, 32'h0000_0600, 1, 0, -1, 0, 5, 0, 0, 1, 2};
        vecs[5] = '{32'hFFFF_FFFC, 32'h0000_0500, 2, 0, -1, 0, 9, 0, 0, 2, 4};
        vecs[6] = '{32'h0000_0060, 32'h0000_0800, 2, 0, -1, 1, 9, 0, 0, 2, 4};
        vecs[7] = '{32'h0000_0030, 32'h0000_0700, 3, 1, -1, 0, 19, 0, 0, 3, 6};
        vecs[8] = '{32'h0000_0240, 32'h0000_0A00, 2, 3, 0, 0, 3, 1, 2, 0, 1};
        HRESET = 1'b1;
        start = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        word_count = '0;
        repeat (3) @(negedge HCLK);
        HRESET = 1'b0;
        @(negedge HCLK);
        chk("rst_htrans", 64'(bus.HTRANS), 64'd0);
        chk("rst_haddr", 64'(bus.HADDR), 64'd0);
        chk("rst_hwrite_hwdata", {31'd0, bus.HWRITE, bus.HWDATA}, 64'd0);
        chk("rst_status", {60'd0, busy, done, error, 1'b0}, 64'd0);
        chk("rst_words_left", 64'(words_left), 64'd0);
        chk("const_ctrl", {bus.HSIZE, bus.HBURST, bus.HPROT, bus.HMASTLOCK}, {3'b010, 3'b000, 4'b0011, 1'b0});
        for (int i = 0; i < 9; i++) run(vecs[i], i);
        waits_cfg = 2;
        err_at = -1;
        @(negedge HCLK);
        src_addr = 32'h80;
        dst_addr = 32'h900;
        word_count = 16'd2;
        start = 1'b1;
        @(negedge HCLK);
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (bus.HTRANS == 2'b00 && bus.HWRITE && busy) found = 1;
            else @(negedge HCLK);
        end
        chk("rst_reach_wr_data", 64'(found), 64'd1);
        HRESET = 1'b1;
        @(posedge HCLK);
        #1;
        chk("rst_mid_htrans", 64'(bus.HTRANS), 64'd0);
        chk("rst_mid_busy_done", {62'd0, busy, done}, 64'd0);
        @(negedge HCLK);
        HRESET = 1'b0;
        done_seen = 0;
        trans_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge HCLK);
            done_seen |= done;
            trans_seen |= bus.HTRANS != 2'b00;
        end
        chk("rst_mid_no_done", 64'(done_seen), 64'd0);
        chk("rst_mid_bus_idle", 64'(trans_seen), 64'd0);
        exp_wr_q.delete();
        exp_rd_q.delete();
        rd_p = rd_n;
        wr_p = wr_n;
        run(vecs[4], 9);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ahb_lite_copy_master.md
Name: ahb_lite_copy_master

Overview:
Single-master AHB-Lite initiator that copies a block of 32-bit words from a source address to a destination address on the same AHB-Lite bus. Each word is moved with one single read transfer followed by one single write transfer. The block sits where the bus master normally attaches, or behind a master mux, and drives the team's AHB-Lite memory and peripheral slaves. It gives firmware and testbenches a bus initiator without the processor.

Parameters:
CNT_W, 16, width of the word-count input and internal remaining-word counter

Ports:
HCLK  input  1  bus clock, all logic on rising edge
HRESET  input  1  synchronous, active-high reset
start  input  1  one-cycle command strobe, accepted only when busy=0
src_addr  input  32  source byte address, sampled on accepted start, bits[1:0] forced to 0
dst_addr  input  32  destination byte address, sampled on accepted start, bits[1:0] forced to 0
word_count  input  CNT_W  number of words to copy, sampled on accepted start
busy  output  1  high while a copy is in progress
done  output  1  one-cycle pulse at end of copy, successful or aborted
error  output  1  sticky HRESP error flag, cleared on next accepted start
words_left  output  CNT_W  remaining-word counter
HADDR  output  32  address-phase address
HTRANS  output  2  IDLE=2'b00 or NONSEQ=2'b10 only
HWRITE  output  1  address-phase direction
HSIZE  output  3  constant 3'b010 (word)
HBURST  output  3  constant 3'b000 (SINGLE)
HPROT  output  4  constant 4'b0011
HMASTLOCK  output  1  constant 0
HWDATA  output  32  write data, valid in write data phase
HRDATA  input  32  read data
HREADY  input  1  transfer-complete/extend from slave mux
HRESP  input  1  0=OKAY, 1=ERROR

Behaviour:
- Reset: state=IDLE; HTRANS=00, HADDR=0, HWRITE=0, HWDATA=0, busy=0, done=0, error=0, words_left=0, internal buffer=0. Reset mid-copy aborts at once; no done pulse is issued.
- All outputs are registered. The FSM advances only on HREADY=1 at a clock edge, except for the error exit.
- IDLE: on start=1, latch the addresses and count and clear error.
  - If count=0: go to DONE with no bus transfer.
  - Otherwise: go to RD_A, busy=1.
- start while busy=1 is ignored.
- RD_A: HTRANS=NONSEQ, HWRITE=0, HADDR=src. On HREADY go to RD_D and drive HTRANS=IDLE.
- RD_D: on HREADY&~HRESP, capture HRDATA into the buffer and go to WR_A.
- WR_A: HTRANS=NONSEQ, HWRITE=1, HADDR=dst. On HREADY go to WR_D, drive HTRANS=IDLE and HWDATA=buffer.
- WR_D: hold HWDATA stable until HREADY. On HREADY&~HRESP:
  - src+=4, dst+=4, words_left-=1.
  - If words_left was 1, go to DONE; otherwise go to RD_A.
- Error: HRESP=1 in RD_D or WR_D sets error=1 and goes to DONE on the first ERROR cycle (HREADY=0). HTRANS is already IDLE, so the second response cycle needs nothing. words_left holds the count of words not yet completed, including the failing one.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Addresses wrap modulo 2^32 (0xFFFFFFFC+4=0x00000000). No 1KB-boundary handling is needed because every transfer is SINGLE.
- Zero-wait-state latency: first HTRANS=NONSEQ appears the cycle after start. Each word takes 4 cycles. done rises 4N+1 cycles after the start edge.
- Each wait state inserted by the slave adds exactly one cycle. Address-phase signals stay stable while HREADY=0.
- The master never issues back-to-back pipelined transfers. Bus utilisation is deliberately 50% for simplicity.

Test Plan:
- Zero-wait memory preloaded with 0x11111111..0x44444444 at 0x00000000-0x0C; src=0x0, dst=0x100, count=4 -> 0x100-0x10C hold the same 4 words; done pulses at cycle 17; error=0; words_left=0.
- count=0 -> no NONSEQ ever driven; done pulses once, 1 cycle after start; busy never high.
- Slave inserts 2 wait states on every data phase, count=2 -> data copied correctly; HADDR/HWRITE/HWDATA stable through waits; done at cycle 4*2+1+8=17.
- Slave returns ERROR on the second read (src=0x200, count=3) -> error=1, done pulse, only 1 word written, words_left=2, no further NONSEQ; next start clears error.
- src=0xFFFFFFFC, count=2 -> second read address is 0x00000000.
- start re-asserted mid-copy -> ignored. HRESET asserted during WR_D -> next cycle HTRANS=00, busy=0, no done pulse.
